wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source A: the in-order ALU/branch pipeline result.
  - Source B: the long-latency unit (load/multi-cycle ops).
- Sits between those producers and the regfile write port (rdvalid/rdnum/rddata).
- Guarantees one regfile write per cycle, correct write order on same-rd conflicts, and bounded wait for B.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive B losses before B is forced to win; legal range 1..7.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- a_valid_i  in  1  source A request.
- a_ready_o  out  1  source A accepted this cycle.
- a_rdnum_i  in  5  source A destination register.
- a_rddata_i  in  XLEN  source A write data.
- b_valid_i  in  1  source B request.
- b_ready_o  out  1  source B accepted this cycle.
- b_rdnum_i  in  5  source B destination register.
- b_rddata_i  in  XLEN  source B write data.
- rdvalid_o  out  1  regfile write enable (registered).
- rdnum_o  out  5  regfile write index (registered).
- rddata_o  out  XLEN  regfile write data (registered).
- b_prio_o  out  1  FSM is in B_PRIO (perf/debug).

Behaviour:
- Handshake:
  - Transfer happens on valid & ready.
  - A producer holds valid and payload stable until accepted.
  - ready_o is combinational from the current inputs and state, with no dependency on the regfile.
- x0 requests (rdnum == 0):
  - Always ready = 1 when valid.
  - Consumed without using the port; never written.
- Arbitration, over nonzero-rd valid requests only:
  - Only one requester: it is granted.
  - Both, and a_rdnum_i == b_rdnum_i: grant B and stall A. B is the older instruction, so order is B write then A write.
  - Both, different rd, state B_PRIO: grant B.
  - Both, different rd, state NORMAL: grant A.
  - Exactly one nonzero-rd grant per cycle maximum.
- Output register (latency 1 cycle from accept):
  - Next cycle: rdvalid_o = 1, rdnum_o/rddata_o = winner's payload.
  - No grant: rdvalid_o = 0, rdnum_o = 0, rddata_o = 0.
- Starvation counter, cnt (CNT_W bits):
  - B valid, nonzero rd, not granted: cnt += 1; saturates at STARVE_LIMIT.
  - B granted, or B not valid: cnt = 0.
- FSM, states NORMAL and B_PRIO:
  - NORMAL -> B_PRIO when a B loss makes cnt reach STARVE_LIMIT.
  - B_PRIO -> NORMAL on B grant, or if b_valid_i drops (protocol violation, recovered silently).
  - cnt cleared on every exit from B_PRIO.
- Reset (rst == 0 at posedge):
  - State NORMAL, cnt = 0.
  - rdvalid_o = 0, rdnum_o = 0, rddata_o = 0, b_prio_o = 0.
  - a_ready_o = b_ready_o = 0 combinationally while rst == 0.
  - Reset mid-stream discards any pending output write and any unaccepted requests; no write appears the cycle after reset.
- Simultaneous events:
  - x0 on one side plus nonzero-rd on the other: both accepted in the same cycle.
  - Both x0: both accepted, no write.

Decomposition:
- Shared package:
  - XLEN.
  - REGNUM_W = 5.
  - Arbiter state encoding: NORMAL = 0, B_PRIO = 1.
  - Default STARVE_LIMIT.
- No sub-module. Arbitration, counter/FSM and output register stay flat in one module.

Test Plan:
- A only, rd=5, data=0x00001234 -> a_ready_o=1 same cycle; next cycle rdvalid_o=1, rdnum_o=5, rddata_o=0x00001234.
- A rd=3/0xAAAA, B rd=7/0xBBBB, both valid -> cycle0 a_ready=1, b_ready=0; cycle1 write rd3=0xAAAA and B accepted; cycle2 write rd7=0xBBBB.
- A rd=9/0x1, B rd=9/0x2, both valid -> B accepted first (write rd9=0x2), A accepted next cycle (write rd9=0x1); final rd9=0x1.
- STARVE_LIMIT=4, A valid every cycle rd=1 with new data, B held valid rd=2 -> B loses cycles 0-3 while b_prio_o rises after the 4th loss; B granted cycle 4; cnt=0 and b_prio_o=0 afterwards.
- A rd=0, B rd=4/0xCAFE same cycle -> a_ready=1 and b_ready=1; next cycle single write rd4=0xCAFE; no write with rdnum 0 ever observed.
- Grant in cycle N, rst=0 at posedge N+1 -> rdvalid_o=0 after reset, ready outputs 0 during reset, FSM in NORMAL, b_prio_o=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths, state encoding and defaults for the writeback arbiter
package wb_port_arbiter_pkg;

  localparam int XLEN             = 32;
  localparam int REGNUM_W         = 5;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    B_PRIO = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - two writeback sources plus the regfile write port
interface wb_port_arbiter_if #(
  parameter int XLEN = wb_port_arbiter_pkg::XLEN
);
  import wb_port_arbiter_pkg::*;

  logic                a_valid_i;
  logic                a_ready_o;
  logic [REGNUM_W-1:0] a_rdnum_i;
  logic [XLEN-1:0]     a_rddata_i;
  logic                b_valid_i;
  logic                b_ready_o;
  logic [REGNUM_W-1:0] b_rdnum_i;
  logic [XLEN-1:0]     b_rddata_i;
  logic                rdvalid_o;
  logic [REGNUM_W-1:0] rdnum_o;
  logic [XLEN-1:0]     rddata_o;
  logic                b_prio_o;

  modport slave (
    input  a_valid_i, a_rdnum_i, a_rddata_i,
    input  b_valid_i, b_rdnum_i, b_rddata_i,
    output a_ready_o, b_ready_o,
    output rdvalid_o, rdnum_o, rddata_o, b_prio_o
  );

  modport master (
    output a_valid_i, a_rdnum_i, a_rddata_i,
    output b_valid_i, b_rdnum_i, b_rddata_i,
    input  a_ready_o, b_ready_o,
    input  rdvalid_o, rdnum_o, rddata_o, b_prio_o
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares one regfile write port between the ALU pipe (A) and long-latency unit (B)
module wb_port_arbiter #(
  parameter int XLEN         = wb_port_arbiter_pkg::XLEN,
  parameter int STARVE_LIMIT = wb_port_arbiter_pkg::STARVE_LIMIT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  import wb_port_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t          state;
  logic [CNT_W-1:0]    cnt;

  logic                a_x0, b_x0, a_req, b_req;
  logic                grant_a, grant_b;
  logic                b_loss;
  logic [REGNUM_W-1:0] wnum;
  logic [XLEN-1:0]     wdata;

  always_comb begin
    a_x0  = bus.a_valid_i && (bus.a_rdnum_i == '0);
    b_x0  = bus.b_valid_i && (bus.b_rdnum_i == '0);
    a_req = bus.a_valid_i && (bus.a_rdnum_i != '0);
    b_req = bus.b_valid_i && (bus.b_rdnum_i != '0);

    // B is the older instruction, so a same-rd collision must let B write first.
    grant_b = b_req && (!a_req || (bus.a_rdnum_i == bus.b_rdnum_i) || (state == B_PRIO));
    grant_a = a_req && !grant_b;
    b_loss  = b_req && !grant_b;

    bus.a_ready_o = rst && (a_x0 || grant_a);
    bus.b_ready_o = rst && (b_x0 || grant_b);

    wnum  = '0;
    wdata = '0;
    if (grant_b) begin
      wnum  = bus.b_rdnum_i;
      wdata = bus.b_rddata_i;
    end else if (grant_a) begin
      wnum  = bus.a_rdnum_i;
      wdata = bus.a_rddata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= NORMAL;
      cnt          <= '0;
      bus.rdvalid_o <= 1'b0;
      bus.rdnum_o   <= '0;
      bus.rddata_o  <= '0;
      bus.b_prio_o  <= 1'b0;
    end else begin
      bus.rdvalid_o <= grant_a || grant_b;
      bus.rdnum_o   <= wnum;
      bus.rddata_o  <= wdata;

      if (b_loss)
        cnt <= (cnt == LIMIT) ? cnt : cnt + 1'b1;
      else
        cnt <= '0;

      case (state)
        NORMAL: begin
          if (b_loss && (cnt + 1'b1 == LIMIT)) begin
            state        <= B_PRIO;
            bus.b_prio_o <= 1'b1;
          end
        end
        B_PRIO: begin
          // A dropped b_valid_i here is a protocol slip; fall back quietly.
          if (grant_b || !bus.b_valid_i || b_x0) begin
            state        <= NORMAL;
            bus.b_prio_o <= 1'b0;
            cnt          <= '0;
          end
        end
        default: begin
          state        <= NORMAL;
          bus.b_prio_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
